vm1_trap_seq: RTL and testbench

Trap and interrupt sequencer for the 1801VM1 soft CPU. It latches synchronous trap requests and samples external interrupt lines against the current PSW priority. At an instruction boundary it selects the winning source and runs the PDP-11 entry sequence on the CPU bus: push PSW, push PC, fetch new PC, fetch new PSW. It sits beside the datapath, owns the bus while `busy` is high, and hands new PC/PSW/SP values to the datapath through write strobes.

---
 rtl/vm1_trap_pkg.sv | 35 +++
 rtl/vm1_trap_prio.sv | 64 ++++++
 rtl/vm1_trap_seq.sv | 210 +++++++++++++++++++++
 tb/tb_vm1_trap_seq.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/vm1_trap_pkg.sv
// Shared vectors, source indices and state encoding for the VM1 trap/interrupt sequencer.
package vm1_trap_pkg;

    localparam logic [15:0] VEC_BUSERR = 16'o4;
    localparam logic [15:0] VEC_ERR    = 16'o10;
    localparam logic [15:0] VEC_BPT    = 16'o14;
    localparam logic [15:0] VEC_IOT    = 16'o20;
    localparam logic [15:0] VEC_EMT    = 16'o30;
    localparam logic [15:0] VEC_TRAP   = 16'o34;

    localparam int N_SRC      = 6;
    localparam int SRC_BUSERR = 0;
    localparam int SRC_ERR    = 1;
    localparam int SRC_BPT    = 2;
    localparam int SRC_IOT    = 3;
    localparam int SRC_EMT    = 4;
    localparam int SRC_TRAP   = 5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PUSH_PSW,
        ST_PUSH_PC,
        ST_RD_PC,
        ST_RD_PSW,
        ST_HALT
    } state_t;

    // Level of irq[n]: base + n, saturating at 7.
    function automatic logic [2:0] irq_level(input logic [2:0] base, input int n);
        logic [3:0] sum;
        sum = {1'b0, base} + 4'(n);
        return (sum > 4'd7) ? 3'd7 : sum[2:0];
    endfunction

endpackage

// File: rtl/vm1_trap_prio.sv
// Combinational winner select: latched traps, then trace, then highest irq above the PSW priority.
// Zero latency, no state.
module vm1_trap_prio
    import vm1_trap_pkg::*;
#(
    parameter logic [15:0] IRQ_VEC_BASE = 16'o000100,
    parameter logic [2:0]  IRQ_LEVEL0   = 3'd4
) (
    input  logic [N_SRC-1:0] pend,
    input  logic [3:0]       irq,
    input  logic [2:0]       ipl,
    input  logic             trace,
    output logic             win_vld,
    output logic [15:0]      win_vec,
    output logic [N_SRC-1:0] win_src
);

    logic        irq_hit;
    logic [15:0] irq_vec;

    // Later (higher-numbered) lines overwrite earlier hits.
    always_comb begin
        irq_hit = 1'b0;
        irq_vec = 16'd0;
        for (int n = 0; n < 4; n++) begin
            if (irq[n] && (irq_level(IRQ_LEVEL0, n) > ipl)) begin
                irq_hit = 1'b1;
                irq_vec = IRQ_VEC_BASE + 16'(4 * n);
            end
        end
    end

    always_comb begin
        win_vld = 1'b1;
        win_vec = 16'd0;
        win_src = '0;
        if (pend[SRC_BUSERR]) begin
            win_vec = VEC_BUSERR;
            win_src[SRC_BUSERR] = 1'b1;
        end else if (pend[SRC_ERR]) begin
            win_vec = VEC_ERR;
            win_src[SRC_ERR] = 1'b1;
        end else if (pend[SRC_BPT]) begin
            win_vec = VEC_BPT;
            win_src[SRC_BPT] = 1'b1;
        end else if (pend[SRC_IOT]) begin
            win_vec = VEC_IOT;
            win_src[SRC_IOT] = 1'b1;
        end else if (pend[SRC_EMT]) begin
            win_vec = VEC_EMT;
            win_src[SRC_EMT] = 1'b1;
        end else if (pend[SRC_TRAP]) begin
            win_vec = VEC_TRAP;
            win_src[SRC_TRAP] = 1'b1;
        end else if (trace) begin
            win_vec = VEC_BPT;
        end else if (irq_hit) begin
            win_vec = irq_vec;
        end else begin
            win_vld = 1'b0;
        end
    end

endmodule

// File: rtl/vm1_trap_seq.sv
// VM1 trap/interrupt entry sequencer: push PSW, push PC, fetch PC, fetch PSW; bus_req the cycle after boundary.
// Each transfer holds until bus_ack, with a one-cycle gap between them. VM1_TRACE_TRAP_EN enables trace traps on PSW.T.
module vm1_trap_seq
    import vm1_trap_pkg::*;
#(
    parameter logic [15:0] IRQ_VEC_BASE = 16'o000100,
    parameter logic [2:0]  IRQ_LEVEL0   = 3'd4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ce,
    input  logic        boundary,
    input  logic        req_buserr,
    input  logic        req_err,
    input  logic        req_bpt,
    input  logic        req_iot,
    input  logic        req_emt,
    input  logic        req_trap,
    input  logic [3:0]  irq,
    input  logic [15:0] psw,
    input  logic [15:0] pc,
    input  logic [15:0] sp,
    output logic        busy,
    output logic        done,
    output logic        halted,
    output logic        bus_req,
    output logic        bus_we,
    output logic [15:0] bus_addr,
    output logic [15:0] bus_wdata,
    input  logic [15:0] bus_rdata,
    input  logic        bus_ack,
    input  logic        bus_fault,
    output logic        sp_wr,
    output logic        pc_wr,
    output logic        psw_wr,
    output logic [15:0] sp_new,
    output logic [15:0] pc_new,
    output logic [15:0] psw_new
);

    state_t            state_q, state_d;
    logic [N_SRC-1:0]  pend_q, pend_d;
    logic [15:0]       vec_q, vec_d;
    logic [15:0]       pc_old_q, pc_old_d;
    logic              bus_req_q, bus_req_d;
    logic              bus_we_q, bus_we_d;
    logic [15:0]       bus_addr_q, bus_addr_d;
    logic [15:0]       bus_wdata_q, bus_wdata_d;

    logic              trace_req;
    logic              win_vld;
    logic [15:0]       win_vec;
    logic [N_SRC-1:0]  win_src;
    logic [N_SRC-1:0]  req_v;
    logic              take;
    logic              acc;

`ifdef VM1_TRACE_TRAP_EN
    assign trace_req = psw[4];
`else
    assign trace_req = 1'b0;
`endif

    assign req_v = {req_trap, req_emt, req_iot, req_bpt, req_err, req_buserr};

    vm1_trap_prio #(
        .IRQ_VEC_BASE (IRQ_VEC_BASE),
        .IRQ_LEVEL0   (IRQ_LEVEL0)
    ) u_prio (
        .pend    (pend_q),
        .irq     (irq),
        .ipl     (psw[7:5]),
        .trace   (trace_req),
        .win_vld (win_vld),
        .win_vec (win_vec),
        .win_src (win_src)
    );

    assign busy      = (state_q != ST_IDLE);
    assign halted    = (state_q == ST_HALT);
    assign bus_req   = bus_req_q;
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;

    always_comb begin
        state_d     = state_q;
        vec_d       = vec_q;
        pc_old_d    = pc_old_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        take        = 1'b0;
        done        = 1'b0;
        sp_wr       = 1'b0;
        pc_wr       = 1'b0;
        psw_wr      = 1'b0;
        sp_new      = 16'd0;
        pc_new      = 16'd0;
        psw_new     = 16'd0;
        acc         = ce && bus_req_q && bus_ack;

        case (state_q)
            ST_IDLE: begin
                if (boundary && win_vld) begin
                    take        = 1'b1;
                    state_d     = ST_PUSH_PSW;
                    vec_d       = win_vec;
                    pc_old_d    = pc;
                    bus_req_d   = 1'b1;
                    bus_we_d    = 1'b1;
                    bus_addr_d  = sp - 16'd2;
                    bus_wdata_d = psw;
                end
            end
            ST_PUSH_PSW: begin
                if (acc && !bus_fault) begin
                    sp_wr     = 1'b1;
                    sp_new    = bus_addr_q;
                    bus_req_d = 1'b0;
                    state_d   = ST_PUSH_PC;
                end
            end
            ST_PUSH_PC: begin
                // Gap cycle: sp already reflects the first push.
                if (!bus_req_q) begin
                    bus_req_d   = 1'b1;
                    bus_we_d    = 1'b1;
                    bus_addr_d  = sp - 16'd2;
                    bus_wdata_d = pc_old_q;
                end else if (acc && !bus_fault) begin
                    sp_wr     = 1'b1;
                    sp_new    = bus_addr_q;
                    bus_req_d = 1'b0;
                    state_d   = ST_RD_PC;
                end
            end
            ST_RD_PC: begin
                if (!bus_req_q) begin
                    bus_req_d   = 1'b1;
                    bus_we_d    = 1'b0;
                    bus_addr_d  = vec_q;
                    bus_wdata_d = 16'd0;
                end else if (acc && !bus_fault) begin
                    pc_wr     = 1'b1;
                    pc_new    = bus_rdata;
                    bus_req_d = 1'b0;
                    state_d   = ST_RD_PSW;
                end
            end
            ST_RD_PSW: begin
                if (!bus_req_q) begin
                    bus_req_d   = 1'b1;
                    bus_we_d    = 1'b0;
                    bus_addr_d  = vec_q + 16'd2;
                    bus_wdata_d = 16'd0;
                end else if (acc && !bus_fault) begin
                    psw_wr    = 1'b1;
                    psw_new   = bus_rdata;
                    done      = 1'b1;
                    bus_req_d = 1'b0;
                    state_d   = ST_IDLE;
                end
            end
            default: ;
        endcase

        if (acc && bus_fault) begin
            state_d   = ST_HALT;
            bus_req_d = 1'b0;
        end

        // A new pulse beats the clear of its own latch.
        pend_d = (pend_q & ~(take ? win_src : {N_SRC{1'b0}})) | req_v;

        if (!ce) begin
            done   = 1'b0;
            sp_wr  = 1'b0;
            pc_wr  = 1'b0;
            psw_wr = 1'b0;
            sp_new = 16'd0;
            pc_new = 16'd0;
            psw_new = 16'd0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            pend_q      <= '0;
            vec_q       <= 16'd0;
            pc_old_q    <= 16'd0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= 16'd0;
            bus_wdata_q <= 16'd0;
        end else if (ce) begin
            state_q     <= state_d;
            pend_q      <= pend_d;
            vec_q       <= vec_d;
            pc_old_q    <= pc_old_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
        end
    end

endmodule

// File: tb/tb_vm1_trap_seq.sv
// Directed bench for vm1_trap_seq: zero-wait memory with stall/fault knobs and a tiny SP/PC/PSW datapath.
module tb_vm1_trap_seq;

    logic        clk = 1'b0;
    logic        reset_n, ce, boundary;
    logic        req_buserr, req_err, req_bpt, req_iot, req_emt, req_trap;
    logic [3:0]  irq;
    logic        busy, done, halted, bus_req, bus_we;
    logic [15:0] bus_addr, bus_wdata, bus_rdata;
    logic        bus_ack, bus_fault;
    logic        sp_wr, pc_wr, psw_wr;
    logic [15:0] sp_new, pc_new, psw_new;

    logic [15:0] sp_r, pc_r, psw_r;
    logic [15:0] mem [0:32767];

    logic        ack_en, fault_en;
    logic [15:0] fault_addr;
    logic        ld, pre_vld;
    logic [15:0] ld_sp, ld_pc, ld_psw, pre_a, pre_d;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    vm1_trap_seq dut (
        .clk(clk), .reset_n(reset_n), .ce(ce), .boundary(boundary),
        .req_buserr(req_buserr), .req_err(req_err), .req_bpt(req_bpt),
        .req_iot(req_iot), .req_emt(req_emt), .req_trap(req_trap),
        .irq(irq), .psw(psw_r), .pc(pc_r), .sp(sp_r),
        .busy(busy), .done(done), .halted(halted),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata), .bus_ack(bus_ack), .bus_fault(bus_fault),
        .sp_wr(sp_wr), .pc_wr(pc_wr), .psw_wr(psw_wr),
        .sp_new(sp_new), .pc_new(pc_new), .psw_new(psw_new)
    );

    assign bus_ack   = bus_req & ack_en;
    assign bus_fault = bus_req & fault_en & (bus_addr == fault_addr);
    assign bus_rdata = mem[bus_addr[15:1]];

    // Datapath registers and memory: preload ports plus the DUT's strobes and writes.
    always @(posedge clk) begin
        if (pre_vld) mem[pre_a[15:1]] <= pre_d;
        if (ld) begin
            sp_r  <= ld_sp;
            pc_r  <= ld_pc;
            psw_r <= ld_psw;
        end else if (ce) begin
            if (sp_wr)  sp_r  <= sp_new;
            if (pc_wr)  pc_r  <= pc_new;
            if (psw_wr) psw_r <= psw_new;
            if (bus_req && bus_ack && bus_we && !bus_fault) mem[bus_addr[15:1]] <= bus_wdata;
        end
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0o expected %0o", tag, act, exp);
        end
    endtask

    function automatic logic [15:0] rd(input logic [15:0] a);
        return mem[a[15:1]];
    endfunction

    task automatic poke(input logic [15:0] a, input logic [15:0] d);
        pre_vld = 1'b1; pre_a = a; pre_d = d;
        @(negedge clk);
        pre_vld = 1'b0;
    endtask

    task automatic set_regs(input logic [15:0] s, input logic [15:0] p, input logic [15:0] w);
        ld = 1'b1; ld_sp = s; ld_pc = p; ld_psw = w;
        @(negedge clk);
        ld = 1'b0;
    endtask

    task automatic pulse_req(input logic [5:0] r);
        {req_trap, req_emt, req_iot, req_bpt, req_err, req_buserr} = r;
        @(negedge clk);
        {req_trap, req_emt, req_iot, req_bpt, req_err, req_buserr} = 6'b0;
    endtask

    // Boundary pulse then run to done; cycle 1 is the first cycle after the boundary cycle.
    task automatic run_seq(input string tag, output int done_at,
                           output logic [15:0] pcv, output logic [15:0] pswv);
        done_at = -1; pcv = 16'd0; pswv = 16'd0;
        boundary = 1'b1;
        @(negedge clk);
        boundary = 1'b0;
        for (int k = 1; k <= 40 && done_at < 0; k++) begin
            if (k == 1) check({tag, "_entry"}, {busy, bus_req}, 2'b11);
            if (pc_wr)  pcv  = pc_new;
            if (psw_wr) pswv = psw_new;
            if (done)   done_at = k;
            @(negedge clk);
        end
    endtask

    task automatic boundary_idle(input string tag);
        boundary = 1'b1;
        @(negedge clk);
        boundary = 1'b0;
        check(tag, {busy, bus_req}, 2'b00);
        @(negedge clk);
    endtask

    initial begin
        int          d;
        logic [15:0] p, w;
        int          bad;
        logic        seen;

        reset_n = 1'b0; ce = 1'b1; boundary = 1'b0; irq = 4'd0;
        {req_trap, req_emt, req_iot, req_bpt, req_err, req_buserr} = 6'b0;
        ack_en = 1'b1; fault_en = 1'b0; fault_addr = 16'd0;
        ld = 1'b0; pre_vld = 1'b0; ld_sp = 0; ld_pc = 0; ld_psw = 0; pre_a = 0; pre_d = 0;
        repeat (2) @(negedge clk);
        check("rst_ctl", {busy, done, halted, bus_req, bus_we, sp_wr, pc_wr, psw_wr}, 8'h00);
        check("rst_bus", {bus_addr, bus_wdata, sp_new, pc_new}, 64'd0);
        check("rst_psw_new", psw_new, 16'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // EMT entry
        poke(16'o30, 16'o4000); poke(16'o32, 16'o0);
        set_regs(16'o1000, 16'o2000, 16'o340);
        pulse_req(6'b010000);
        run_seq("emt", d, p, w);
        check("emt_done_at", d, 7);
        check("emt_pc_new", p, 16'o4000);
        check("emt_psw_new", w, 16'o0);
        check("emt_push_psw", rd(16'o776), 16'o340);
        check("emt_push_pc", rd(16'o774), 16'o2000);
        check("emt_sp", sp_r, 16'o774);
        check("emt_idle", busy, 1'b0);

        // Simultaneous buserr + iot
        poke(16'o4, 16'o6000);  poke(16'o6, 16'o340);
        poke(16'o20, 16'o7000); poke(16'o22, 16'o340);
        set_regs(16'o1000, 16'o100, 16'o0);
        pulse_req(6'b001001);
        run_seq("sim1", d, p, w);
        check("sim1_pc_new", p, 16'o6000);
        check("sim1_psw_new", w, 16'o340);
        run_seq("sim2", d, p, w);
        check("sim2_pc_new", p, 16'o7000);
        check("sim2_done_at", d, 7);
        boundary_idle("sim3_no_entry");

        // IRQ masking
        irq = 4'b0011;
        poke(16'o104, 16'o5000); poke(16'o106, 16'o340);
        set_regs(16'o1000, 16'o2000, 16'o200);
        run_seq("irq", d, p, w);
        check("irq_pc_new", p, 16'o5000);
        check("irq_psw_new", w, 16'o340);
        set_regs(16'o1000, 16'o2000, 16'o240);
        boundary_idle("irq_masked");
        irq = 4'b0000;

        // Trace
        poke(16'o14, 16'o3000); poke(16'o16, 16'o0);
        set_regs(16'o1000, 16'o2000, 16'o020);
`ifdef VM1_TRACE_TRAP_EN
        run_seq("trace", d, p, w);
        check("trace_pc_new", p, 16'o3000);
`else
        boundary_idle("trace_ignored");
`endif

        // SP wrap-around and bus stall
        poke(16'o34, 16'o1234); poke(16'o36, 16'o0);
        set_regs(16'o0, 16'o2222, 16'o340);
        pulse_req(6'b100000);
        ack_en = 1'b0;
        boundary = 1'b1;
        @(negedge clk);
        boundary = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("stall_ctl", {bus_req, bus_we, sp_wr}, 3'b110);
            check("stall_bus", {bus_addr, bus_wdata}, {16'o177776, 16'o340});
            @(negedge clk);
        end
        ce = 1'b0; ack_en = 1'b1;
        @(negedge clk);
        check("ce_hold", {sp_r, bus_addr, 1'b0, sp_wr}, {16'o0, 16'o177776, 2'b00});
        ce = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (bus_req && bus_we && bus_addr == 16'o177774) seen = 1'b1;
            else @(negedge clk);
        end
        check("wrap_push_pc_seen", seen, 1'b1);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (done) seen = 1'b1;
            @(negedge clk);
        end
        check("wrap_done_seen", seen, 1'b1);
        check("wrap_sp", sp_r, 16'o177774);
        check("wrap_mem", {rd(16'o177776), rd(16'o177774)}, {16'o340, 16'o2222});
        check("wrap_pc", pc_r, 16'o1234);

        // Double fault during PUSH_PC
        poke(16'o10, 16'o4444); poke(16'o12, 16'o0);
        set_regs(16'o1000, 16'o2000, 16'o340);
        fault_en = 1'b1; fault_addr = 16'o774;
        pulse_req(6'b000010);
        boundary = 1'b1;
        @(negedge clk);
        boundary = 1'b0;
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            if (pc_wr || psw_wr || done) bad++;
            @(negedge clk);
        end
        check("dfault_no_strobes", bad, 0);
        check("dfault_state", {halted, busy, bus_req}, 3'b110);
        check("dfault_regs", {pc_r, sp_r}, {16'o2000, 16'o776});
        reset_n = 1'b0;
        #1;
        check("dfault_rst_ctl", {busy, done, halted, bus_req, bus_we, sp_wr, pc_wr, psw_wr}, 8'h00);
        check("dfault_rst_bus", {bus_addr, bus_wdata, sp_new, pc_new}, 64'd0);
        @(negedge clk);
        reset_n = 1'b1; fault_en = 1'b0;
        @(negedge clk);
        boundary_idle("post_rst_idle");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
